// File: rtl/demux21b_stream.sv
// ---------------------------------------------------------------------------
// demux21b_stream
//
// Stream 1:2 demultiplexer, the receiving-end counterpart of mux21b.
// One input word stream (valid/ready) is steered into one of two output
// channels, A or B. Each channel owns a single-entry holding register with
// its own valid/ready, so each consumer can apply backpressure on its own.
//
// The route is either the explicit in_sel bit (0 = A, 1 = B) or, in TDM
// mode, an internal phase that alternates A,B,A,B on every accepted word.
//
// Ports:
//   clk       rising-edge clock, single domain
//   rst       synchronous active-high reset
//   alt_mode  1 = route by internal phase, 0 = route by in_sel
//   in_valid  input word present
//   in_ready  block accepts the input word this cycle
//   in_data   input word (WIDTH bits)
//   in_sel    explicit route, ignored while alt_mode = 1
//   a_valid   channel A holding register full
//   a_ready   channel A consumer accepts
//   a_data    channel A word
//   b_valid   channel B holding register full
//   b_ready   channel B consumer accepts
//   b_data    channel B word
//   a_count   words accepted into A, modulo 2^CNT_W
//   b_count   words accepted into B, modulo 2^CNT_W
//   phase     TDM state: 0 = EXPECT_A, 1 = EXPECT_B
// ---------------------------------------------------------------------------
module demux21b_stream #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alt_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [WIDTH-1:0] b_data,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count,
  output logic             phase
);

  localparam logic [0:0] EXPECT_A = 1'b0;
  localparam logic [0:0] EXPECT_B = 1'b1;

  logic [0:0]       phase_q;
  logic             a_valid_q;
  logic             b_valid_q;
  logic [WIDTH-1:0] a_data_q;
  logic [WIDTH-1:0] b_data_q;
  logic [CNT_W-1:0] a_count_q;
  logic [CNT_W-1:0] b_count_q;

  logic tgt;
  logic tgt_valid;
  logic tgt_ready;
  logic accept;
  logic load_a;
  logic load_b;
  logic drain_a;
  logic drain_b;

  // Route selection and input handshake. in_ready depends combinationally
  // on the target channel's ready so a full register that is draining this
  // cycle can be refilled in the same cycle (1 word/cycle per channel).
  always_comb begin
    tgt       = alt_mode ? phase_q[0] : in_sel;
    tgt_valid = tgt ? b_valid_q : a_valid_q;
    tgt_ready = tgt ? b_ready   : a_ready;
    in_ready  = !rst && (!tgt_valid || tgt_ready);
    accept    = in_valid && in_ready;
    load_a    = accept && !tgt;
    load_b    = accept &&  tgt;
    drain_a   = a_valid_q && a_ready;
    drain_b   = b_valid_q && b_ready;
  end

  // Channel A holding register and counter. A load wins over a drain, so
  // the valid bit stays set when the old word leaves as the new one lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_data_q  <= '0;
      a_count_q <= '0;
    end else begin
      if (load_a) begin
        a_valid_q <= 1'b1;
        a_data_q  <= in_data;
        a_count_q <= a_count_q + CNT_W'(1);
      end else if (drain_a) begin
        a_valid_q <= 1'b0;
      end
    end
  end

  // Channel B holding register and counter, mirror of channel A.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid_q <= 1'b0;
      b_data_q  <= '0;
      b_count_q <= '0;
    end else begin
      if (load_b) begin
        b_valid_q <= 1'b1;
        b_data_q  <= in_data;
        b_count_q <= b_count_q + CNT_W'(1);
      end else if (drain_b) begin
        b_valid_q <= 1'b0;
      end
    end
  end

  // TDM phase. Held at EXPECT_A outside TDM mode so every entry into TDM
  // starts on channel A; advances only on an accepted word.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= EXPECT_A;
    end else if (!alt_mode) begin
      phase_q <= EXPECT_A;
    end else if (accept) begin
      case (phase_q)
        EXPECT_A: phase_q <= EXPECT_B;
        EXPECT_B: phase_q <= EXPECT_A;
        default:  phase_q <= EXPECT_A;
      endcase
    end
  end

  assign a_valid = a_valid_q;
  assign b_valid = b_valid_q;
  assign a_data  = a_data_q;
  assign b_data  = b_data_q;
  assign a_count = a_count_q;
  assign b_count = b_count_q;
  assign phase   = phase_q[0];

endmodule

// File: tb/tb_demux21b_stream.sv
// ---------------------------------------------------------------------------
// tb_demux21b_stream
//
// Bench for demux21b_stream. A scoreboard process computes, from the
// routing rules, which channel each accepted word belongs to and pushes it
// onto that channel's expected queue; a monitor process pops and compares
// whenever a channel presents a word. Directed sequences are followed by a
// long randomized run.
// ---------------------------------------------------------------------------
module tb_demux21b_stream;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;
  localparam int CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             alt_mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_data;
  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_data;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;
  logic             phase;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  // Reference state: words expected on each channel in order, the TDM
  // position and the number of words routed to each channel since reset.
  logic [WIDTH-1:0] qa[$];
  logic [WIDTH-1:0] qb[$];
  logic             mphase = 1'b0;
  int               cnta   = 0;
  int               cntb   = 0;

  demux21b_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .alt_mode (alt_mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic s,
                               input logic alt, input logic ar, input logic br, input logic r);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    alt_mode = alt;
    a_ready  = ar;
    b_ready  = br;
    rst      = r;
  endtask

  // Settle point for directed checks: after the monitor and scoreboard.
  task automatic settle();
    @(negedge clk);
    #2;
  endtask

  // Monitor: every word a channel presents must be the oldest expected word
  // for that channel; it leaves the queue when the consumer takes it.
  always @(negedge clk) begin
    if (armed && !rst) begin
      if (a_valid) begin
        if (qa.size() == 0) checkOutput("a_valid_no_word", 32'(a_valid), 32'd0);
        else begin
          checkOutput("a_data", 32'(a_data), 32'(qa[0]));
          if (a_ready) void'(qa.pop_front());
        end
      end
      if (b_valid) begin
        if (qb.size() == 0) checkOutput("b_valid_no_word", 32'(b_valid), 32'd0);
        else begin
          checkOutput("b_data", 32'(b_data), 32'(qb[0]));
          if (b_ready) void'(qb.pop_front());
        end
      end
    end
  end

  // Scoreboard: after the monitor has removed words leaving this cycle, a
  // non-empty queue means that channel stays occupied, so the input can
  // only be taken when the target queue is empty.
  always @(negedge clk) begin
    logic t;
    logic exp_ready;
    #1;
    if (armed) begin
      if (rst) exp_ready = 1'b0;
      else begin
        t = alt_mode ? mphase : in_sel;
        exp_ready = t ? (qb.size() == 0) : (qa.size() == 0);
      end
      checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
      checkOutput("phase", 32'(phase), 32'(mphase));
      checkOutput("a_count", 32'(a_count), 32'(cnta % CMOD));
      checkOutput("b_count", 32'(b_count), 32'(cntb % CMOD));
      if (rst) begin
        qa.delete();
        qb.delete();
        mphase = 1'b0;
        cnta   = 0;
        cntb   = 0;
      end else begin
        if (in_valid && exp_ready) begin
          if (t) begin qb.push_back(in_data); cntb++; end
          else   begin qa.push_back(in_data); cnta++; end
          if (alt_mode) mphase = ~mphase;
        end
        if (!alt_mode) mphase = 1'b0;
      end
    end
  end

  initial begin
    logic alt_r;
    rst = 1'b1; alt_mode = 1'b0; in_valid = 1'b0; in_data = '0;
    in_sel = 1'b0; a_ready = 1'b1; b_ready = 1'b1;

    // Reset values.
    applyStimulus(0, 16'h0, 0, 0, 1, 1, 1);
    armed = 1'b1;
    settle();
    checkOutput("rst_a_valid", 32'(a_valid), 0);
    checkOutput("rst_b_valid", 32'(b_valid), 0);
    checkOutput("rst_a_data", 32'(a_data), 0);
    checkOutput("rst_b_data", 32'(b_data), 0);
    checkOutput("rst_in_ready", 32'(in_ready), 0);

    // Explicit routing.
    applyStimulus(1, 16'h1111, 0, 0, 1, 1, 0);
    applyStimulus(1, 16'h2222, 1, 0, 1, 1, 0);
    settle();
    checkOutput("t1_a_valid", 32'(a_valid), 1);
    checkOutput("t1_a_data", 32'(a_data), 32'h1111);
    applyStimulus(0, 16'h0, 0, 0, 1, 1, 0);
    settle();
    checkOutput("t1_b_data", 32'(b_data), 32'h2222);
    checkOutput("t1_counts", {a_count, b_count}, {8'd1, 8'd1});

    // Backpressure on A, then release.
    applyStimulus(1, 16'hAAAA, 0, 0, 0, 1, 0);
    applyStimulus(1, 16'hBBBB, 0, 0, 0, 1, 0);
    settle();
    checkOutput("t2_in_ready_stall", 32'(in_ready), 0);
    checkOutput("t2_a_data_hold", 32'(a_data), 32'hAAAA);
    applyStimulus(1, 16'hBBBB, 0, 0, 0, 1, 0);
    applyStimulus(1, 16'hBBBB, 0, 0, 1, 1, 0);
    settle();
    checkOutput("t2_in_ready_release", 32'(in_ready), 1);
    applyStimulus(0, 16'h0, 0, 0, 0, 1, 0);
    settle();
    checkOutput("t2_a_valid", 32'(a_valid), 1);
    checkOutput("t2_a_data", 32'(a_data), 32'hBBBB);
    applyStimulus(0, 16'h0, 0, 0, 1, 1, 0);

    // TDM stream with random in_sel.
    for (int i = 1; i <= 6; i++) applyStimulus(1, WIDTH'(i), 1'($urandom), 1, 1, 1, 0);
    applyStimulus(0, 16'h0, 0, 1, 1, 1, 0);
    settle();
    checkOutput("t3_counts", {a_count, b_count}, {8'd6, 8'd4});
    checkOutput("t3_phase", 32'(phase), 0);

    // TDM with B stalled after it holds 0x0002.
    applyStimulus(1, 16'h0001, 0, 1, 1, 1, 0);
    applyStimulus(1, 16'h0002, 0, 1, 1, 1, 0);
    applyStimulus(1, 16'h0003, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 16'h0004, 1, 1, 1, 0, 0);
    settle();
    checkOutput("t4_in_ready", 32'(in_ready), 0);
    checkOutput("t4_phase", 32'(phase), 1);
    checkOutput("t4_b_data", 32'(b_data), 32'h0002);
    applyStimulus(1, 16'h0004, 0, 1, 1, 1, 0);
    applyStimulus(0, 16'h0, 0, 0, 1, 1, 0);

    // Counter wrap on A after a fresh reset.
    applyStimulus(0, 16'h0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 256; i++) applyStimulus(1, WIDTH'($urandom), 0, 0, 1, 1, 0);
    applyStimulus(0, 16'h0, 0, 0, 1, 1, 0);
    settle();
    checkOutput("t5_a_wrap", 32'(a_count), 0);
    checkOutput("t5_b_count", 32'(b_count), 0);

    // Reset with both channels full and the input stalled.
    applyStimulus(1, 16'h5A5A, 0, 0, 0, 0, 0);
    applyStimulus(1, 16'hA5A5, 1, 0, 0, 0, 0);
    applyStimulus(1, 16'h1234, 0, 0, 0, 0, 0);
    applyStimulus(1, 16'h1234, 0, 0, 0, 0, 1);
    settle();
    checkOutput("t6_in_ready_rst", 32'(in_ready), 0);
    applyStimulus(0, 16'h0, 0, 0, 0, 0, 0);
    settle();
    checkOutput("t6_valids", {a_valid, b_valid}, 0);
    checkOutput("t6_counts", {a_count, b_count}, 0);
    checkOutput("t6_phase", 32'(phase), 0);
    checkOutput("t6_in_ready", 32'(in_ready), 1);

    // Randomized traffic with occasional mode switches and resets.
    alt_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) alt_r = ~alt_r;
      applyStimulus($urandom_range(0, 3) != 0, WIDTH'($urandom), 1'($urandom), alt_r,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 299) == 0);
    end

    // Drain: every expected word must have come out.
    for (int i = 0; i < 10; i++) applyStimulus(0, 16'h0, 0, 0, 1, 1, 0);
    settle();
    checkOutput("drain_a_left", 32'(qa.size()), 0);
    checkOutput("drain_b_left", 32'(qb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux21b_stream.md
Name: demux21b_stream

Overview:
- Stream 1:2 demultiplexer; the receiving-end counterpart of the mux21b 2:1 selector.
- Accepts one word stream with valid/ready handshake and routes each word to output channel A or B.
- Routing uses either an explicit select bit or an internal alternating (TDM) phase.
- Each output has a one-entry holding register with its own valid/ready, so each channel applies backpressure independently; per-channel transfer counters support bring-up and benches.

Parameters:
- WIDTH, 16, data word width in bits.
- CNT_W, 8, width of each per-channel accepted-word counter.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- alt_mode  input  1  1 = route by internal alternating phase (A,B,A,B...); 0 = route by in_sel.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  1  explicit route (0 = A, 1 = B), same polarity as mux21b; ignored when alt_mode=1.
- a_valid  output  1  channel A holding register full.
- a_ready  input  1  channel A consumer accepts.
- a_data  output  WIDTH  channel A word.
- b_valid  output  1  channel B holding register full.
- b_ready  input  1  channel B consumer accepts.
- b_data  output  WIDTH  channel B word.
- a_count  output  CNT_W  words accepted into A, modulo 2^CNT_W.
- b_count  output  CNT_W  words accepted into B, modulo 2^CNT_W.
- phase  output  1  TDM state: 0 = EXPECT_A, 1 = EXPECT_B.

Behaviour:
- Reset (rst=1 at a clk edge):
  - a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0, phase=0.
  - in_ready is forced 0 while rst=1.
  - Reset mid-transfer discards held words; no output handshake completes in a reset cycle.
- Target channel, combinational: tgt = alt_mode ? phase : in_sel.
- in_ready, combinational, when rst=0:
  - = !tgt_valid | tgt_ready, i.e. target register empty or draining this cycle.
  - The path from a_ready/b_ready to in_ready is intentional; no skid buffer.
- Accept = in_valid & in_ready. On accept:
  - Target register loads in_data and target valid=1 at the next edge (latency 1 cycle, accept to *_valid).
  - Target counter increments by 1 and wraps from 2^CNT_W-1 to 0.
- Drain = x_valid & x_ready. On drain without a load to that channel, x_valid clears at the next edge; x_data holds its last value.
- Load and drain of the same channel in the same cycle: new word replaces the old one and x_valid stays 1, giving full throughput of 1 word/cycle per channel.
- Stall: while x_valid=1 and x_ready=0, x_data is stable.
- Accepts into A and drains of B, or the reverse, proceed independently in the same cycle.
- Phase state machine:
  - EXPECT_A -> EXPECT_B on accept when alt_mode=1.
  - EXPECT_B -> EXPECT_A on accept when alt_mode=1.
  - No transition without an accept.
  - While alt_mode=0, phase is driven to EXPECT_A at every edge, so each entry into TDM mode starts on A.
  - Changing alt_mode mid-stream affects only tgt for the current cycle; held words are unaffected.
- A blocked target stalls the whole input: head-of-line blocking is required, and words are never reordered or dropped.
- in_valid=0: in_data and in_sel are don't-care; no state change other than drains.

Test Plan:
- Reset then explicit mode: send 0x1111 sel=0, 0x2222 sel=1, both readies=1 -> a_data=0x1111 and b_data=0x2222 each valid 1 cycle after accept; a_count=1, b_count=1; in_ready=1 throughout.
- Backpressure: a_ready=0, send 0xAAAA sel=0 then 0xBBBB sel=0 -> first accepted; in_ready=0 while second is presented and a_data holds 0xAAAA. Raise a_ready -> same cycle in_ready=1, 0xBBBB accepted, a_valid stays 1 with a_data=0xBBBB.
- TDM mode: alt_mode=1, stream 0x0001..0x0006 back-to-back, readies=1 -> A gets 1,3,5 and B gets 2,4,6; phase toggles every cycle; in_sel is random and has no effect; counts=3/3.
- TDM with B stalled: b_ready=0 after B holds 0x0002 -> 0x0003 goes to A, then in_ready=0 with phase=1 until b_ready=1; no word is lost.
- Counter wrap: 256 words to A with CNT_W=8 -> a_count returns to 0; b_count is unchanged.
- Reset mid-stream: assert rst with a_valid=b_valid=1 and a stalled input -> next cycle all valids=0, counts=0, phase=0; in_ready=0 during rst and 1 after.
